// File: rtl/rc4_key_pkg.sv
// Shared types and defaults for the RC4 key-search result path.
package rc4_key_pkg;

    typedef enum logic [1:0] {
        SEARCHING = 2'd0,
        FOUND     = 2'd1,
        FAILED    = 2'd2
    } collector_state_t;

    localparam int DEFAULT_KEY_W    = 24;
    localparam int DEFAULT_NUM_INST = 4;

endpackage

// File: rtl/first_set_idx.sv
// Combinational priority encoder: reports whether any request is set and
// the index of the lowest set bit.
module first_set_idx
    import rc4_key_pkg::*;
#(
    parameter int NUM_INST = DEFAULT_NUM_INST,
    parameter int ID_W     = (NUM_INST > 1) ? $clog2(NUM_INST) : 1
) (
    input  logic [NUM_INST-1:0] req,
    output logic                any,
    output logic [ID_W-1:0]     idx
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        any = |req;
        idx = '0;
        for (int i = NUM_INST - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/key_result_collector.sv
// Merges the results of parallel RC4 key-search instances: latches the first
// found key, broadcasts stop, and flags exhaustion when every instance gave up.
module key_result_collector
    import rc4_key_pkg::*;
#(
    parameter int NUM_INST = DEFAULT_NUM_INST,
    parameter int KEY_W    = DEFAULT_KEY_W,
    parameter int ID_W     = (NUM_INST > 1) ? $clog2(NUM_INST) : 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_INST-1:0]            key_found,
    input  logic [NUM_INST-1:0]            search_done,
    input  logic [NUM_INST-1:0][KEY_W-1:0] secret_key,
    input  logic                           restart,
    output logic [KEY_W-1:0]               secretKey_out,
    output logic                           stop_search,
    output logic                           key_valid,
    output logic                           all_failed,
    output logic [ID_W-1:0]                winner_id,
    output logic [KEY_W/4-1:0][3:0]        hex_digit,
    output logic                           disp_blank
);

    collector_state_t      state;
    collector_state_t      next_state;
    logic [NUM_INST-1:0]   fail_mask;
    logic                  hit_any;
    logic [ID_W-1:0]       hit_idx;
    logic                  all_done;

    first_set_idx #(
        .NUM_INST (NUM_INST),
        .ID_W     (ID_W)
    ) u_first_set_idx (
        .req (key_found),
        .any (hit_any),
        .idx (hit_idx)
    );

    // The current cycle's search_done counts toward exhaustion.
    assign all_done = &(fail_mask | search_done);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= SEARCHING;
        end else begin
            state <= next_state;
        end
    end

    // A found key wins over a simultaneous completion of the fail mask.
    always_comb begin
        next_state = state;
        if (restart) begin
            next_state = SEARCHING;
        end else if (state == SEARCHING) begin
            if (hit_any) begin
                next_state = FOUND;
            end else if (all_done) begin
                next_state = FAILED;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fail_mask     <= '0;
            secretKey_out <= '0;
            winner_id     <= '0;
        end else if (restart) begin
            fail_mask     <= '0;
            secretKey_out <= '0;
            winner_id     <= '0;
        end else if (state == SEARCHING) begin
            fail_mask <= fail_mask | search_done;
            if (hit_any) begin
                secretKey_out <= secret_key[hit_idx];
                winner_id     <= hit_idx;
            end
        end
    end

    always_comb begin
        stop_search = 1'b0;
        key_valid   = 1'b0;
        all_failed  = 1'b0;
        disp_blank  = 1'b1;
        case (state)
            FOUND: begin
                stop_search = 1'b1;
                key_valid   = 1'b1;
                disp_blank  = 1'b0;
            end
            FAILED: begin
                stop_search = 1'b1;
                all_failed  = 1'b1;
                disp_blank  = 1'b0;
            end
            default: begin
                stop_search = 1'b0;
            end
        endcase
    end

    assign hex_digit = secretKey_out;

endmodule
